// File: rtl/tidc_pkg.sv
// tidc_pkg: shared definitions for the TIDC L2 command arbiter.
//   - L2 command type encodings driven on l2_cmd_type
//   - arbiter FSM state enum
package tidc_pkg;

  localparam logic [2:0] L2_CMD_READ  = 3'b000;
  localparam logic [2:0] L2_CMD_WRITE = 3'b001;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tidc_rr_arbiter.sv
// tidc_rr_arbiter: round-robin grant over N requesters.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   i_req       - request vector
//   i_en        - grant enable; no grant when low
//   i_advance   - a grant was accepted this cycle; move pointer past the winner
//   o_grant     - one-hot grant (combinational)
//   o_idx       - index of the granted requester
// The search for a winner starts at the internal pointer r_rr_ptr.
module tidc_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  input  logic                 i_advance,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] r_rr_ptr;
  logic            w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (int'(r_rr_ptr) + k) % N;
      if (i_en && !w_found && i_req[j]) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (i_advance) begin
      r_rr_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/tidc_l2_cmd_arbiter.sv
// tidc_l2_cmd_arbiter: shares the single L2 command/response port among N_REQ
// requesters. Round-robin grant, one outstanding command, response routed to
// the issuing requester.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   req_valid/req_ready            - per-requester handshake (ready one-hot)
//   req_type/addr/data/size/dirty  - flattened per-requester command fields
//   rsp_valid                      - one-cycle pulse to the command owner
//   rsp_data, rsp_error            - shared response payload, held until next response
//   l2_cmd_*                       - registered L2 command, valid pulses one cycle
//   l2_response_*                  - L2 response strobe and payload
//   busy                           - FSM not idle
//   stray_rsp                      - sticky: L2 response seen outside WAIT
// Build option: define TIDC_L2ARB_WATCHDOG_EN to abort a WAIT after TIMEOUT
// cycles with an error response to the owner.
module tidc_l2_cmd_arbiter
  import tidc_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [3*N_REQ-1:0]    req_type,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [4*N_REQ-1:0]    req_size,
  input  logic [N_REQ-1:0]      req_dirty,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_error,
  output logic                  l2_cmd_valid,
  output logic [2:0]            l2_cmd_type,
  output logic [ADDR_W-1:0]     l2_cmd_addr,
  output logic [DATA_W-1:0]     l2_cmd_data,
  output logic [3:0]            l2_cmd_size,
  output logic                  l2_cmd_dirty,
  input  logic                  l2_response_valid,
  input  logic [DATA_W-1:0]     l2_response_data,
  input  logic                  l2_response_error,
  output logic                  busy,
  output logic                  stray_rsp
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("tidc_l2_cmd_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_e r_state, w_state_d;

  logic [N_REQ-1:0]  w_grant;
  logic [IdxW-1:0]   w_idx;
  logic [IdxW-1:0]   r_owner;
  logic [N_REQ-1:0]  w_owner_oh;
  logic              w_hs;
  logic              w_rsp_take;
  logic              w_wd_expire;

  logic              r_cmd_valid;
  logic [2:0]        r_cmd_type;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_data;
  logic [3:0]        r_cmd_size;
  logic              r_cmd_dirty;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_error;
  logic              r_stray;

  // Grant is gated by rst_n so req_ready reads 0 while reset is held.
  tidc_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_en      ((r_state == StIdle) && rst_n),
    .i_advance (w_hs),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  assign w_hs       = |(req_valid & w_grant);
  assign w_rsp_take = (r_state == StWait) && l2_response_valid;
  assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

`ifdef TIDC_L2ARB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] r_wd_cnt;

  // Counts WAIT cycles; the TIMEOUT-th WAIT cycle without a response expires.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == StIssue) begin
      r_wd_cnt <= '0;
    end else if (r_state == StWait) begin
      r_wd_cnt <= r_wd_cnt + WdW'(1);
    end
  end

  assign w_wd_expire = (r_state == StWait) && !l2_response_valid &&
                       (r_wd_cnt == WdW'(TIMEOUT - 1));
`else
  assign w_wd_expire = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (w_rsp_take || w_wd_expire) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= '0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_cmd_size  <= '0;
      r_cmd_dirty <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      // Command fields are captured at the handshake so they are on the port in ISSUE.
      r_cmd_valid <= w_hs;
      if (w_hs) begin
        r_owner     <= w_idx;
        r_cmd_type  <= req_type[w_idx*3 +: 3];
        r_cmd_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
        r_cmd_data  <= req_data[w_idx*DATA_W +: DATA_W];
        r_cmd_size  <= req_size[w_idx*4 +: 4];
        r_cmd_dirty <= req_dirty[w_idx];
      end
      r_rsp_valid <= '0;
      if (w_rsp_take) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_data  <= l2_response_data;
        r_rsp_error <= l2_response_error;
      end else if (w_wd_expire) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_data  <= '0;
        r_rsp_error <= 1'b1;
      end
      if (l2_response_valid && r_state != StWait) begin
        r_stray <= 1'b1;
      end
    end
  end

  assign req_ready    = w_grant;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_error    = r_rsp_error;
  assign l2_cmd_valid = r_cmd_valid;
  assign l2_cmd_type  = r_cmd_type;
  assign l2_cmd_addr  = r_cmd_addr;
  assign l2_cmd_data  = r_cmd_data;
  assign l2_cmd_size  = r_cmd_size;
  assign l2_cmd_dirty = r_cmd_dirty;
  assign busy         = (r_state != StIdle);
  assign stray_rsp    = r_stray;

endmodule

// File: tb/tb_tidc_l2_cmd_arbiter.sv
// Self-checking bench for tidc_l2_cmd_arbiter (N_REQ=4, TIMEOUT=16).
module tb_tidc_l2_cmd_arbiter;
  import tidc_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_dirty, rsp_valid;
  logic [3*N-1:0]  req_type;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_data;
  logic [4*N-1:0]  req_size;
  logic [DW-1:0]   rsp_data, l2_cmd_data, l2_response_data;
  logic            rsp_error, l2_cmd_valid, l2_cmd_dirty;
  logic [2:0]      l2_cmd_type;
  logic [AW-1:0]   l2_cmd_addr;
  logic [3:0]      l2_cmd_size;
  logic            l2_response_valid, l2_response_error, busy, stray_rsp;

  logic [2:0]    f_type  [N];
  logic [AW-1:0] f_addr  [N];
  logic [DW-1:0] f_data  [N];
  logic [3:0]    f_size  [N];
  logic          f_dirty [N];

  always_comb begin
    req_type  = '0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    req_dirty = '0;
    for (int i = 0; i < N; i++) begin
      req_type[i*3 +: 3]   = f_type[i];
      req_addr[i*AW +: AW] = f_addr[i];
      req_data[i*DW +: DW] = f_data[i];
      req_size[i*4 +: 4]   = f_size[i];
      req_dirty[i]         = f_dirty[i];
    end
  end

  tidc_l2_cmd_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_type          (req_type),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_size          (req_size),
    .req_dirty         (req_dirty),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_error         (rsp_error),
    .l2_cmd_valid      (l2_cmd_valid),
    .l2_cmd_type       (l2_cmd_type),
    .l2_cmd_addr       (l2_cmd_addr),
    .l2_cmd_data       (l2_cmd_data),
    .l2_cmd_size       (l2_cmd_size),
    .l2_cmd_dirty      (l2_cmd_dirty),
    .l2_response_valid (l2_response_valid),
    .l2_response_data  (l2_response_data),
    .l2_response_error (l2_response_error),
    .busy              (busy),
    .stray_rsp         (stray_rsp)
  );

  int   checks   = 0;
  int   failures = 0;
  int   rr_m     = 0;     // model: next requester to be favoured
  logic stray_m  = 1'b0;  // model: sticky stray flag

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      f_type[i]  = ($urandom_range(0, 1) == 0) ? L2_CMD_READ : L2_CMD_WRITE;
      f_addr[i]  = $urandom;
      f_data[i]  = rand_wide();
      f_size[i]  = 4'($urandom_range(0, 15));
      f_dirty[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Winner = the valid requester closest at or after the favoured one, cyclically.
  function automatic int winner(input logic [N-1:0] m);
    for (int o = 0; o < N; o++) begin
      if (m[(rr_m + o) % N]) return (rr_m + o) % N;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, DW'(req_ready), '0);
    chk({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_error"}, DW'(rsp_error), '0);
    chk({tag, "_cmd_valid"}, DW'(l2_cmd_valid), '0);
    chk({tag, "_cmd_type"}, DW'(l2_cmd_type), '0);
    chk({tag, "_cmd_addr"}, DW'(l2_cmd_addr), '0);
    chk({tag, "_cmd_data"}, l2_cmd_data, '0);
    chk({tag, "_cmd_size"}, DW'(l2_cmd_size), '0);
    chk({tag, "_cmd_dirty"}, DW'(l2_cmd_dirty), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_stray"}, DW'(stray_rsp), '0);
  endtask

  // One cycle of reset from wherever the DUT is; the in-flight command is dropped.
  task automatic do_reset(input string tag);
    rst_n             = 1'b0;
    req_valid         = '0;
    l2_response_valid = 1'b0;
    tick();
    chk_all_zero(tag);
    rst_n   = 1'b1;
    rr_m    = 0;
    stray_m = 1'b0;
  endtask

  // Present mask, check the grant and the command pulse one cycle later.
  task automatic issue(input logic [N-1:0] mask, output int w);
    req_valid = mask;
    #1;
    w = winner(mask);
    chk("req_ready", DW'(req_ready), DW'(N'(1) << w));
    chk("busy_idle", DW'(busy), '0);
    tick();
    req_valid = mask & ~(N'(1) << w);
    rr_m = (w + 1) % N;
    chk("cmd_valid", DW'(l2_cmd_valid), 1);
    chk("cmd_type", DW'(l2_cmd_type), DW'(f_type[w]));
    chk("cmd_addr", DW'(l2_cmd_addr), DW'(f_addr[w]));
    chk("cmd_data", l2_cmd_data, f_data[w]);
    chk("cmd_size", DW'(l2_cmd_size), DW'(f_size[w]));
    chk("cmd_dirty", DW'(l2_cmd_dirty), DW'(f_dirty[w]));
    chk("ready_busy", DW'(req_ready), '0);
    chk("busy_issue", DW'(busy), 1);
  endtask

  // L2 answers k cycles after the command pulse; owner sees rsp_valid one cycle later.
  task automatic respond(input int w, input int k, input logic [DW-1:0] d, input logic e);
    for (int j = 0; j < k; j++) begin
      tick();
      chk("no_early_rsp", DW'(rsp_valid), '0);
      chk("cmd_one_pulse", DW'(l2_cmd_valid), '0);
    end
    req_valid         = '0;
    l2_response_valid = 1'b1;
    l2_response_data  = d;
    l2_response_error = e;
    tick();
    l2_response_valid = 1'b0;
    chk("rsp_valid", DW'(rsp_valid), DW'(N'(1) << w));
    chk("rsp_data", rsp_data, d);
    chk("rsp_error", DW'(rsp_error), DW'(e));
    chk("busy_done", DW'(busy), '0);
    chk("stray_hold", DW'(stray_rsp), DW'(stray_m));
  endtask

  initial begin
    int w;
    logic [DW-1:0] d;
    rst_n             = 1'b0;
    req_valid         = '0;
    l2_response_valid = 1'b0;
    l2_response_data  = '0;
    l2_response_error = 1'b0;
    rand_fields();
    tick();
    do_reset("reset");

    // Single read from requester 2, L2 answers with k=1.
    f_type[2] = L2_CMD_READ;
    f_addr[2] = 32'h0000_1000;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = 32'h8080_8090 + i;
    issue(4'b0100, w);
    respond(w, 1, d, 1'b0);

    // Fairness from reset: all valid, then only 1 and 3.
    do_reset("reset_fair");
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      issue(4'b1111, w);
      respond(w, 1, rand_wide(), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      issue(4'b1010, w);
      respond(w, 2, rand_wide(), 1'b0);
    end

    // Write passthrough from requester 0.
    f_type[0]  = L2_CMD_WRITE;
    f_addr[0]  = 32'h0000_2000;
    f_data[0]  = {(DW / 8){8'hA5}};
    f_dirty[0] = 1'b1;
    f_size[0]  = 4'd5;
    issue(4'b0001, w);
    respond(w, 3, rand_wide(), 1'b1);

    // Stray response while idle.
    l2_response_valid = 1'b1;
    l2_response_data  = rand_wide();
    tick();
    l2_response_valid = 1'b0;
    stray_m = 1'b1;
    chk("stray_set", DW'(stray_rsp), 1);
    chk("stray_no_rsp", DW'(rsp_valid), '0);
    tick();
    tick();
    chk("stray_sticky", DW'(stray_rsp), 1);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      rand_fields();
      issue(m, w);
      respond(w, $urandom_range(1, 4), rand_wide(), 1'($urandom_range(0, 1)));
    end

    // Silent L2.
    rand_fields();
    issue(4'b0110, w);
`ifdef TIDC_L2ARB_WATCHDOG_EN
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("wd_no_rsp", DW'(rsp_valid), '0);
    end
    tick();
    chk("wd_rsp_valid", DW'(rsp_valid), DW'(N'(1) << w));
    chk("wd_rsp_error", DW'(rsp_error), 1);
    chk("wd_rsp_data", rsp_data, '0);
    chk("wd_busy", DW'(busy), '0);
    req_valid         = '0;
    l2_response_valid = 1'b1;
    tick();
    l2_response_valid = 1'b0;
    chk("wd_late_stray", DW'(stray_rsp), 1);
    chk("wd_late_no_rsp", DW'(rsp_valid), '0);
    issue(4'b1000, w);
`else
    for (int j = 0; j < 40; j++) tick();
    chk("hang_busy", DW'(busy), 1);
    chk("hang_no_rsp", DW'(rsp_valid), '0);
`endif

    // Reset while waiting on L2, then a normal transaction starting at requester 0.
    tick();
    do_reset("reset_wait");
    tick();
    chk("post_reset_no_rsp", DW'(rsp_valid), '0);
    rand_fields();
    issue(4'b1111, w);
    respond(w, 1, rand_wide(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
